data_bus_responder: RTL
=======================

Name: data_bus_responder

Overview:
- Bus-side responder for the multi-cycle CPU's data bus; the CPU control FSM is the initiator.
- Accepts `transfer`/`busWe` requests with address, write data and funct3 size code, and performs sized, aligned accesses to an internal word RAM.
- Completes each request after a programmable number of wait states with a one-cycle `ready` pulse and an optional `err`.
- Sits between the CPU datapath and data memory; replaces the zero-latency RAM model.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words in RAM. Word index = addr[31:2].
- WAIT_STATES, 2: extra cycles between request acceptance and `ready`. Legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- transfer  in  1  request valid; held high by initiator until `ready`.
- busWe  in  1  1 = store, 0 = load; sampled with `transfer`.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- funct3  in  3  access size/sign code (instrCode[14:12]).
- rdata  out  32  load result, aligned and extended.
- ready  out  1  one-cycle completion pulse.
- err  out  1  valid only with `ready`; access rejected.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; ready=0, err=0, rdata=0, wait counter=0; latched request cleared.
  - RAM contents are not reset.
  - Reset during WAIT or RESP aborts the access; no RAM write occurs.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if transfer=1 at a clock edge, latch addr, wdata, busWe and funct3; load counter=WAIT_STATES; next state = WAIT if WAIT_STATES>0, else RESP.
  - WAIT: counter decrements each cycle; when counter==1, next state = RESP. Inputs are ignored; only latched values are used. transfer dropping mid-wait is a protocol violation and the access still completes.
  - RESP: ready=1 for exactly this cycle; err is valid. Next state = IDLE unconditionally. transfer is not sampled in RESP.
- Latency: transfer first high in IDLE in cycle 0 → ready high in cycle WAIT_STATES+1.
  - Back-to-back: transfer high in the IDLE cycle after RESP starts a new access.
  - The CPU normally drops transfer after ready, so there is no double-accept.
- Stores (busWe=1): the RAM write commits at the rising edge ending the RESP cycle, and only if err=0.
  - funct3 000 SB: 1 byte lane = addr[1:0].
  - funct3 001 SH: lanes {addr[1],0}+1 and {addr[1],0}.
  - funct3 010 SW: all 4 lanes.
  - Unselected bytes are unchanged.
- Loads (busWe=0): rdata is registered on entry to RESP.
  - 000 LB and 100 LBU: byte at addr[1:0], sign- / zero-extended.
  - 001 LH and 101 LHU: half at addr[1], sign- / zero-extended.
  - 010 LW: full word.
  - rdata holds its value until the next load's RESP; the CPU samples it one cycle later (writeback state).
  - Stores and errored accesses do not modify rdata, except that an errored load sets rdata=0.
- err=1 (with ready) when any of the following holds:
  - half access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - addr[31:2] ≥ DEPTH_WORDS;
  - invalid funct3: 011, 110, 111, or stores with funct3 ≥ 011.
  - Errored accesses take the same latency. No write occurs.
- Outputs are registered; no combinational path from inputs to ready, err or rdata.

Decomposition:
- Package bus_pkg holds:
  - funct3 size localparams: LB, LH, LW, LBU, LHU, SB, SH, SW;
  - the responder state enum {IDLE, WAIT, RESP};
  - the WAIT_STATES counter width constant (4).
- One combinational sub-module, bus_lane_align, contains:
  - store path: byte-enable mask and lane-shifted write word, from addr[1:0]/funct3/wdata;
  - load path: lane extraction and sign/zero extension;
  - the misalignment/invalid-size flag.
- The RAM array and FSM stay in data_bus_responder.

Test Plan:
- SW then LW, WAIT_STATES=2: SW addr=0x10 wdata=0xDEADBEEF → ready in cycle 3, err=0. LW addr=0x10 → rdata=0xDEADBEEF in ready cycle and the cycle after.
- Sized stores and loads on word 0x20 preset to 0x11223344:
  - SB addr=0x21 wdata=0xAB → LW gives 0x1122AB44.
  - LB addr=0x21 → 0xFFFFFFAB.
  - LBU addr=0x21 → 0x000000AB.
  - LH addr=0x22 → 0x00001122.
- Misaligned and out-of-range accesses:
  - LW addr=0x12 → ready+err=1, rdata=0.
  - SH addr=0x31 → err=1 and the word is unchanged.
  - LW addr=DEPTH_WORDS*4 → err=1.
- Latency sweep over WAIT_STATES=0,1,5: ready asserts in exactly cycle WAIT_STATES+1, and is high for one cycle only.
- Reset during an SW in WAIT (reset=0 for 1 cycle) → ready never asserts, state IDLE, and a following LW of that address returns the old value.
- Back-to-back: transfer held high across RESP → a second access starts in the next IDLE cycle; both complete with correct data.

Source files
------------

// File: rtl/data_bus_responder_pkg.sv
// Shared types and constants for the CPU data-bus responder and its lane aligner.
// No logic, no latency, no backpressure.
package bus_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam int WS_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } bus_state_e;

endpackage

// File: rtl/data_bus_responder_if.sv
// CPU data-bus handshake: initiator raises transfer, responder answers with a ready pulse.
// Latency set by the responder; initiator holds transfer until ready.
interface data_bus_if;
    logic        transfer;
    logic        busWe;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    modport master (
        output transfer, busWe, addr, wdata, funct3,
        input  rdata, ready, err
    );

    modport slave (
        input  transfer, busWe, addr, wdata, funct3,
        output rdata, ready, err
    );
endinterface

// File: rtl/data_bus_responder_lane_align.sv
// Byte-lane steering for sized accesses: store mask/shifted word, load extract/extend, size/alignment fault.
// Purely combinational, zero latency, no backpressure.
module bus_lane_align
    import bus_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    input  logic        is_store_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o,
    output logic        bad_o
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        shifted  = rword_i >> {addr_lo_i, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

        be_o    = 4'b0000;
        wword_o = wdata_i;
        rdata_o = '0;
        bad_o   = 1'b0;

        if (is_store_i) begin
            // Replicate the narrow datum across all lanes; the mask picks the live ones.
            case (funct3_i)
                SB: begin
                    be_o    = 4'b0001 << addr_lo_i;
                    wword_o = {4{wdata_i[7:0]}};
                end
                SH: begin
                    be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                    wword_o = {2{wdata_i[15:0]}};
                    bad_o   = addr_lo_i[0];
                end
                SW: begin
                    be_o  = 4'b1111;
                    bad_o = |addr_lo_i;
                end
                default: bad_o = 1'b1;
            endcase
        end else begin
            case (funct3_i)
                LB:  rdata_o = {{24{byte_sel[7]}}, byte_sel};
                LBU: rdata_o = {24'h0, byte_sel};
                LH: begin
                    rdata_o = {{16{half_sel[15]}}, half_sel};
                    bad_o   = addr_lo_i[0];
                end
                LHU: begin
                    rdata_o = {16'h0, half_sel};
                    bad_o   = addr_lo_i[0];
                end
                LW: begin
                    rdata_o = rword_i;
                    bad_o   = |addr_lo_i;
                end
                default: bad_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/data_bus_responder.sv
// Data-bus responder: sized aligned accesses to an internal word RAM, answered with ready/err.
// Latency WAIT_STATES+1 cycles from acceptance; initiator stalls on transfer until the ready pulse.
module data_bus_responder
    import bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic      clk,
    input  logic      reset,
    data_bus_if.slave bus
);

    localparam int                  IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0]         DEPTH_L = 30'(DEPTH_WORDS);
    localparam logic [WS_CNT_W-1:0] WS_L    = WS_CNT_W'(WAIT_STATES);
    localparam logic [WS_CNT_W-1:0] CNT_ONE = WS_CNT_W'(1);

    logic [31:0] mem [DEPTH_WORDS];

    bus_state_e          state_q;
    logic [WS_CNT_W-1:0] cnt_q;
    logic [31:0]         addr_q;
    logic [31:0]         wdata_q;
    logic                we_q;
    logic [2:0]          f3_q;
    logic                ready_q;
    logic                err_q;
    logic [31:0]         rdata_q;

    logic             idle;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic             req_we;
    logic [2:0]       req_f3;
    logic             in_range;
    logic [IDX_W-1:0] req_idx;
    logic [31:0]      rd_word;
    logic [3:0]       be;
    logic [31:0]      wword;
    logic [31:0]      ld_data;
    logic             bad;
    logic             acc_err;
    logic             resp_next;

    // With zero wait states the response is formed straight from the bus inputs in IDLE.
    assign idle      = (state_q == IDLE);
    assign req_addr  = idle ? bus.addr   : addr_q;
    assign req_wdata = idle ? bus.wdata  : wdata_q;
    assign req_we    = idle ? bus.busWe  : we_q;
    assign req_f3    = idle ? bus.funct3 : f3_q;

    assign in_range = (req_addr[31:2] < DEPTH_L);
    assign req_idx  = req_addr[IDX_W+1:2];
    assign rd_word  = in_range ? mem[req_idx] : '0;
    assign acc_err  = bad | ~in_range;

    assign resp_next = idle ? (bus.transfer && (WAIT_STATES == 0))
                            : ((state_q == WAIT) && (cnt_q == CNT_ONE));

    bus_lane_align u_align (
        .addr_lo_i  (req_addr[1:0]),
        .funct3_i   (req_f3),
        .is_store_i (req_we),
        .wdata_i    (req_wdata),
        .rword_i    (rd_word),
        .be_o       (be),
        .wword_o    (wword),
        .rdata_o    (ld_data),
        .bad_o      (bad)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= resp_next;
            err_q   <= resp_next & acc_err;
            if (resp_next && !req_we) begin
                rdata_q <= acc_err ? 32'h0 : ld_data;
            end

            case (state_q)
                IDLE: begin
                    if (bus.transfer) begin
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        we_q    <= bus.busWe;
                        f3_q    <= bus.funct3;
                        cnt_q   <= WS_L;
                        state_q <= (WAIT_STATES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= RESP;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Store commits on the edge that ends RESP; a reset before then drops it.
    always_ff @(posedge clk) begin
        if ((state_q == RESP) && we_q && !err_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[req_idx][8*i +: 8] <= wword[8*i +: 8];
                end
            end
        end
    end

    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;

endmodule
